// File: rtl/tick_gen.sv
// Prescaled base tick plus CH_NUM independent divided tick/level channels.
// Divisors are runtime-writable; divisor 0 parks a channel.
module tick_gen #(
  parameter int unsigned IN_FREQ     = 1000000,
  parameter int unsigned BASE_FREQ   = 2000,
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DIV_DEFAULT = 10,
  parameter int unsigned CH_IDX_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                base_tick,
  output logic [CH_NUM-1:0]   tick,
  output logic [CH_NUM-1:0]   level
);

  localparam int unsigned PRE_DIV = IN_FREQ / BASE_FREQ;
  localparam int unsigned PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PRE_W-1:0] pre_cnt_q;
  logic             pre_wrap;

  assign pre_wrap = en && (pre_cnt_q == PRE_W'(PRE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      base_tick <= 1'b0;
    end else if (clear) begin
      pre_cnt_q <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= pre_wrap;
      if (en) begin
        pre_cnt_q <= pre_wrap ? '0 : pre_cnt_q + PRE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             wr_hit;

    // Out-of-range indices can never equal a valid channel number, so they hit nothing.
    assign wr_hit = cfg_we && (cfg_ch == CH_IDX_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_q    <= DIV_W'(DIV_DEFAULT);
        cnt_q    <= '0;
        tick[i]  <= 1'b0;
        level[i] <= 1'b0;
      end else if (clear) begin
        if (wr_hit) begin
          div_q <= cfg_div;
        end
        cnt_q    <= '0;
        tick[i]  <= 1'b0;
        level[i] <= 1'b0;
      end else if (wr_hit) begin
        div_q   <= cfg_div;
        cnt_q   <= '0;
        tick[i] <= 1'b0;
      end else if (pre_wrap && (div_q != '0)) begin
        if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_q    <= '0;
          tick[i]  <= 1'b1;
          level[i] <= ~level[i];
        end else begin
          cnt_q   <= cnt_q + DIV_W'(1);
          tick[i] <= 1'b0;
        end
      end else begin
        tick[i] <= 1'b0;
      end
    end
  end

endmodule
